nbcac_10di_encoder_seq: RTL and testbench
=========================================

// Module: nbcac_10di_encoder_seq
// PURPOSE
//   Sequential NBCAC encoder for 10-bit data words. Maps v[9:0] to a 14-bit codeword d[14:1].
//   It is the upstream counterpart of the NBCAC 10-bit decoder core and drives the bus-side codeword register.
//   Encoding is greedy bit-serial subtraction, one weight per clock, with valid/ready handshakes on both sides.
//   For every v in 0..1023, summing the codeword bits with the weights below returns exactly v.
// PARAMETERS
//   DW  10  data width; only 10 is supported
//   CW  14  codeword width; only 14 is supported
// PORTS
//   clk        in   1   single clock, rising-edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   v is valid
//   in_ready   out  1   encoder idle and able to accept
//   v          in   10  data word
//   out_valid  out  1   codeword valid
//   out_ready  in   1   consumer accepts codeword
//   d          out  14  codeword d[14:1]
//   chk_err    out  1   present only with NBCAC_ENC_SELFCHECK_EN
// BEHAVIOUR
//   - Weights: d1=1, d2=466, d3=288, d4=178, d5=110, d6=68, d7=42.
//     d8=26, d9=16, d10=10, d11=6, d12=4, d13=2, d14=2.
//   - FSM has three states:
//     - IDLE: in_ready=1.
//     - ENC: 13 cycles, index k=2..14.
//     - DONE: out_valid=1.
//   - Accept edge = IDLE with in_valid=1. At that edge:
//     - d1 <= v[0].
//     - rem[8:0] <= v[9:1].
//     - d[14:2] <= 0, k <= 2, state <= ENC.
//   - Each ENC edge: d[k] <= (rem >= h_k); if set, rem <= rem - h_k; k <= k+1.
//     - h_k = weight/2: 233, 144, 89, 55, 34, 21, 13, 8, 5, 3, 2, 1, 1 for k=2..14.
//   - The edge that writes d14 also sets state <= DONE.
//     - out_valid is high 13 edges after the accept edge.
//     - Throughput: one word per 15 cycles, including one DONE->IDLE cycle.
//   - rem is always 0 after k=14: greedy decomposition of 0..511 over the half-weights is exact.
//   - DONE: d and out_valid stay stable until out_ready=1; at that edge state <= IDLE.
//     - out_valid is deasserted one cycle later.
//   - No input is accepted in ENC or DONE (in_ready=0). in_valid in those states is ignored, not queued.
//   - Simultaneous out_ready and in_valid in DONE: only the output handshake completes.
//     The new word is accepted in the next IDLE cycle.
//   - d is held 0 in IDLE and ENC (internal shadow register). d is driven only in DONE.
//   - Reset value of every output: in_ready=1, out_valid=0, d=14'h0000, chk_err=0.
//   - Reset asserted mid-ENC or in DONE: state returns to IDLE immediately. The partial word is discarded.
//   - Arithmetic: rem is a 9-bit unsigned value; compare and subtract happen at 9 bits. No widening is needed.
// CONFIGURATION
//   - NBCAC_ENC_SELFCHECK_EN defined:
//     - An inline weighted-sum decoder recomputes v' from the finished codeword.
//     - When v' != captured v, chk_err is set with out_valid and held for the whole DONE state.
//     - chk_err clears when the state leaves DONE.
//     - Sets only on an RTL fault or SEU. Adds a 10-bit register for v plus an adder tree.
//   - Not defined: the chk_err port and all check logic are absent. Encoder behaviour is otherwise identical.
// TESTING
//   - T1: reset, then v=0 -> out_valid 13 edges after accept, d=14'h0000.
//   - T2: v=1 -> d=14'h0001.
//   - T3: v=2 -> d=14'h1000 (d13 only).
//   - T4: v=1023 -> d=14'h052F (d1,d2,d3,d4,d6,d9,d11 set).
//   - T5: out_ready=0 for 20 cycles with in_valid=1 and v changing.
//     -> d held at first word; in_ready=0 throughout.
//     -> second word accepted in the cycle after out_ready handshake +1.
//   - T6: rst_n pulsed low at ENC k=7 -> d=0, out_valid=0, in_ready=1 immediately.
//     -> next word encodes correctly.
//   - T7: exhaustive v=0..1023 with random out_ready stalls.
//     -> weighted sum of d equals v for every word.
//     -> with NBCAC_ENC_SELFCHECK_EN defined, chk_err stays 0 throughout.

Source files
------------

// File: rtl/nbcac_10di_encoder_seq.sv
// nbcac_10di_encoder_seq
//   Sequential NBCAC encoder: maps a 10-bit data word v to a 14-bit codeword d[14:1].
//   The weights are d1=1 and then 466,288,178,110,68,42,26,16,10,6,4,2,2 for d2..d14.
//
//   Encoding takes one weight per clock.
//   - d1 takes v[0].
//   - The remaining even part, v[9:1], is greedily decomposed over the half-weights for k=2..14.
//     That decomposition is exact for 0..511, so rem always ends at 0.
//
//   Handshake semantics, shared by both ports:
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - in_ready is high only in IDLE. in_valid in ENC or DONE is ignored, not queued.
//   - out_valid is high only in DONE, and d is held stable until out_ready completes the transfer.
//   - In DONE, only the output transfer can complete; a new word waits for the next IDLE cycle.
//
//   Optional feature: define NBCAC_ENC_SELFCHECK_EN to add the chk_err output.
//   - An inline weighted-sum decoder recomputes v from the finished codeword.
//   - chk_err flags a mismatch for the whole DONE state and clears when the state leaves DONE.
//
//   DW and CW exist for documentation only; only DW=10 and CW=14 are supported.
module nbcac_10di_encoder_seq #(
  parameter int DW = 10,
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] d
`ifdef NBCAC_ENC_SELFCHECK_EN
  ,
  output logic          chk_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    k_q;       // index of the codeword bit decided on the next ENC edge
  logic [8:0]    rem_q;     // remaining half-value still to be decomposed
  logic [CW-1:0] cw_q;      // shadow codeword, exposed on d only in DONE
  logic [8:0]    h_k;       // half-weight for the current k
  logic          accept;
  logic          last_k;

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign last_k = (k_q == 4'd14);

  // Half-weight lookup for the bit currently being decided.
  always_comb begin
    h_k = 9'd0;
    case (k_q)
      4'd2:    h_k = 9'd233;
      4'd3:    h_k = 9'd144;
      4'd4:    h_k = 9'd89;
      4'd5:    h_k = 9'd55;
      4'd6:    h_k = 9'd34;
      4'd7:    h_k = 9'd21;
      4'd8:    h_k = 9'd13;
      4'd9:    h_k = 9'd8;
      4'd10:   h_k = 9'd5;
      4'd11:   h_k = 9'd3;
      4'd12:   h_k = 9'd2;
      4'd13:   h_k = 9'd1;
      4'd14:   h_k = 9'd1;
      default: h_k = 9'd0;
    endcase
  end

  // State register; an asynchronous reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, 13 ENC edges, then hold until the consumer takes d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_ENC;
      ST_ENC:  if (last_k)    state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output logic: d is forced to zero except while the codeword is being offered.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    d         = (state_q == ST_DONE) ? cw_q : '0;
  end

  // Datapath: capture on accept, then one greedy compare/subtract per ENC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= 4'd0;
      rem_q <= 9'd0;
      cw_q  <= '0;
    end else if (accept) begin
      cw_q  <= {13'd0, v[0]};
      rem_q <= v[9:1];
      k_q   <= 4'd2;
    end else if (state_q == ST_ENC) begin
      if (rem_q >= h_k) begin
        cw_q[k_q - 4'd1] <= 1'b1;
        rem_q            <= rem_q - h_k;
      end
      k_q <= k_q + 4'd1;
    end
  end

`ifdef NBCAC_ENC_SELFCHECK_EN
  localparam logic [10:0] WEIGHT [14] = '{
    11'd1,   11'd466, 11'd288, 11'd178, 11'd110, 11'd68, 11'd42,
    11'd26,  11'd16,  11'd10,  11'd6,   11'd4,   11'd2,  11'd2
  };

  logic [DW-1:0] v_cap;
  logic [10:0]   v_sum;

  // Keep the accepted word for comparison against the decoded codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_cap <= '0;
    end else if (accept) begin
      v_cap <= v;
    end
  end

  // Weighted-sum decode of the shadow codeword.
  always_comb begin
    v_sum = 11'd0;
    for (int i = 0; i < 14; i++) begin
      if (cw_q[i]) v_sum = v_sum + WEIGHT[i];
    end
  end

  // Flag a mismatch only while the codeword is offered.
  always_comb begin
    chk_err = (state_q == ST_DONE) && (v_sum != {1'b0, v_cap});
  end
`endif

endmodule

// File: tb/tb_nbcac_10di_encoder_seq.sv
// tb_nbcac_10di_encoder_seq
//   Self-checking bench for nbcac_10di_encoder_seq. The reference model decomposes v directly over
//   the full codeword weights and independently checks the weighted sum of every codeword.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Define NBCAC_ENC_SELFCHECK_EN to also watch chk_err.
module tb_nbcac_10di_encoder_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  v_in      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] d;
`ifdef NBCAC_ENC_SELFCHECK_EN
  logic        chk_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [13:0] exp_q[$];

  localparam int WEIGHTS [14] = '{1, 466, 288, 178, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2};

  nbcac_10di_encoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v         (v_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
`ifdef NBCAC_ENC_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Reference model: d1 = parity; the even remainder is decomposed greedily over the codeword weights.
  function automatic logic [13:0] model_enc(input int val);
    logic [13:0] cw;
    int r;
    cw    = '0;
    cw[0] = val[0];
    r     = val - (val % 2);
    for (int i = 1; i < 14; i++) begin
      if (r >= WEIGHTS[i]) begin
        cw[i] = 1'b1;
        r     = r - WEIGHTS[i];
      end
    end
    return cw;
  endfunction

  // Decoded value of a codeword.
  function automatic int weighted_sum(input logic [13:0] cw);
    int s;
    s = 0;
    for (int i = 0; i < 14; i++) if (cw[i]) s += WEIGHTS[i];
    return s;
  endfunction

  // Driver and checker for one word; called at a falling edge with the DUT expected idle.
  task automatic encode_word(input logic [9:0] val, input int stall, output logic [13:0] got);
    int n;
    logic [13:0] exp;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    check("out_valid_idle", out_valid, 0);
    check("d_idle_zero", d, 0);
    in_valid = 1'b1;
    v_in     = val;
    @(negedge clk);
    in_valid = 1'b0;
    v_in     = 10'($urandom);
    exp_q.push_back(model_enc(val));
    check("in_ready_enc", in_ready, 0);
    check("d_enc_zero", d, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 13);
    got = d;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      v_in     = 10'($urandom);
      @(negedge clk);
      check("d_hold", d, got);
      check("out_valid_hold", out_valid, 1);
      check("in_ready_done", in_ready, 0);
    end
`ifdef NBCAC_ENC_SELFCHECK_EN
    check("chk_err", chk_err, 0);
`endif
    out_ready = 1'b1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h3fff;
    check("codeword", d, exp);
    check("weighted_sum", weighted_sum(d), val);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_drop", out_valid, 0);
  endtask

  // Main sequence.
  initial begin
    logic [13:0] got;
    logic [9:0]  a;
    logic [9:0]  b;
    int n;

    // Reset.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
`ifdef NBCAC_ENC_SELFCHECK_EN
    check("rst_chk_err", chk_err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words with literal codewords.
    encode_word(10'd0, 0, got);
    check("t1_v0", got, 14'h0000);
    encode_word(10'd1, 1, got);
    check("t2_v1", got, 14'h0001);
    encode_word(10'd2, 2, got);
    check("t3_v2", got, 14'h1000);
    encode_word(10'd1023, 0, got);
    check("t4_v1023", got, 14'h052F);

    // Long output stall with in_valid held high and v changing.
    a        = 10'($urandom);
    in_valid = 1'b1;
    v_in     = a;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      v_in = 10'($urandom);
      check("t5_in_ready_enc", in_ready, 0);
      @(negedge clk);
      n++;
    end
    check("t5_latency", n, 13);
    for (int i = 0; i < 20; i++) begin
      v_in = 10'($urandom);
      check("t5_d_hold", d, model_enc(a));
      check("t5_in_ready_stall", in_ready, 0);
      @(negedge clk);
    end
    b         = 10'($urandom);
    v_in      = b;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_out_valid_drop", out_valid, 0);
    check("t5_in_ready_after", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_second_accepted", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_second_latency", n, 13);
    check("t5_second_word", d, model_enc(b));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of ENC, while k=7 is being decided.
    in_valid = 1'b1;
    v_in     = 10'd1023;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_enc_rst_d", d, 0);
    check("t6_enc_rst_out_valid", out_valid, 0);
    check("t6_enc_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    encode_word(10'($urandom), 1, got);

    // Reset while a nonzero codeword is offered.
    in_valid = 1'b1;
    v_in     = 10'd1023;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_done_word", d, 14'h052F);
    rst_n = 1'b0;
    #1;
    check("t6_done_rst_d", d, 0);
    check("t6_done_rst_out_valid", out_valid, 0);
    check("t6_done_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    encode_word(10'($urandom), 0, got);

    // Exhaustive sweep with random output stalls.
    for (int i = 0; i < 1024; i++) begin
      encode_word(10'(i), $urandom_range(0, 3), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
